// File: rtl/measure_fre_multi_pkg.sv
// Shared definitions for the multi-channel equal-precision frequency meter:
// channel FSM encoding and parameter defaults.
package measure_fre_multi_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_WIDTH   = 32;
    localparam int DEF_CLK_FRE     = 200000000;
    localparam int DEF_SYNC_STAGES = 2;

    typedef logic [1:0] chan_state_t;

    localparam chan_state_t ST_IDLE  = 2'd0;
    localparam chan_state_t ST_COUNT = 2'd1;
    localparam chan_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/measure_fre_multi_if.sv
// Signal/readout bundle of the frequency meter. The meter is the master;
// the readout side (and the signal source) is the slave.
interface measure_fre_multi_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32
);
    logic                        enable;
    logic [NUM_CH-1:0]           sig_in;
    logic [NUM_CH*CNT_WIDTH-1:0] sig_cnt;
    logic [NUM_CH*CNT_WIDTH-1:0] ref_cnt;
    logic                        cnt_valid;
    logic [NUM_CH-1:0]           ch_ovf;
    logic [NUM_CH-1:0]           ch_nosig;
    logic                        gate_out;

    modport master (
        input  enable, sig_in,
        output sig_cnt, ref_cnt, cnt_valid, ch_ovf, ch_nosig, gate_out
    );

    modport slave (
        output enable, sig_in,
        input  sig_cnt, ref_cnt, cnt_valid, ch_ovf, ch_nosig, gate_out
    );
endinterface

// File: rtl/measure_fre_multi_chan.sv
// One measurement channel: input synchroniser, rising-edge detect, and the
// IDLE/COUNT/DONE gate FSM with saturating signal/reference counters.
module measure_fre_multi_chan
    import measure_fre_multi_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    input  logic                 gate,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] sig_cnt,
    output logic [CNT_WIDTH-1:0] ref_cnt,
    output logic                 ovf,
    output logic                 done
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    logic                   rise_s;
    chan_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]   sig_q, sig_d;
    logic [CNT_WIDTH-1:0]   ref_q, ref_d;
    logic                   ovf_q, ovf_d;

    // Synchroniser shift and edge detect; latency is identical for every edge.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        last_d = sync_q[SYNC_STAGES-1];
        rise_s = sync_q[SYNC_STAGES-1] & ~last_q;
    end

    // Gate FSM: opening edge is not counted, the closing edge is, frame end wins.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        ref_d   = ref_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = ST_IDLE;
            sig_d   = '0;
            ref_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_s && gate) begin
                        state_d = ST_COUNT;
                        sig_d   = '0;
                        ref_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (ref_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        ref_d = ref_q + CNT_WIDTH'(1);
                    end
                    if (rise_s) begin
                        if (sig_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            sig_d = sig_q + CNT_WIDTH'(1);
                        end
                        if (!gate) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_COUNT;
                        end
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            state_q <= ST_IDLE;
            sig_q   <= '0;
            ref_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            last_q  <= last_d;
            state_q <= state_d;
            sig_q   <= sig_d;
            ref_q   <= ref_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sig_cnt = sig_q;
    assign ref_cnt = ref_q;
    assign ovf     = ovf_q;
    assign done    = (state_q == ST_DONE);

endmodule

// File: rtl/measure_fre_multi.sv
// Multi-channel equal-precision frequency meter: shared frame timebase and soft
// gate, per-channel measurement, and latched per-frame results.
module measure_fre_multi
    import measure_fre_multi_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int CLK_FRE       = DEF_CLK_FRE,
    parameter int GATE_CYCLES   = CLK_FRE,
    parameter int PERIOD_CYCLES = 2 * CLK_FRE,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    measure_fre_multi_if.master  bus
);

    localparam int              TB_W    = $clog2(PERIOD_CYCLES);
    localparam logic [TB_W-1:0] TB_LAST = TB_W'(PERIOD_CYCLES - 1);
    localparam logic [TB_W-1:0] TB_GATE = TB_W'(GATE_CYCLES);

    logic [TB_W-1:0]             tb_q, tb_d;
    logic                        gate_q, gate_d;
    logic                        frame_end_s;
    logic                        chan_clr_s;
    logic [NUM_CH*CNT_WIDTH-1:0] sig_cnt_q, sig_cnt_d;
    logic [NUM_CH*CNT_WIDTH-1:0] ref_cnt_q, ref_cnt_d;
    logic                        cnt_valid_q, cnt_valid_d;
    logic [NUM_CH-1:0]           ch_ovf_q, ch_ovf_d;
    logic [NUM_CH-1:0]           ch_nosig_q, ch_nosig_d;

    logic [CNT_WIDTH-1:0]        chan_sig_s [NUM_CH];
    logic [CNT_WIDTH-1:0]        chan_ref_s [NUM_CH];
    logic [NUM_CH-1:0]           chan_ovf_s;
    logic [NUM_CH-1:0]           chan_done_s;

    // Frame timebase and soft gate; disabling parks the timebase at zero.
    always_comb begin
        if (!bus.enable) begin
            tb_d = '0;
        end else if (tb_q == TB_LAST) begin
            tb_d = '0;
        end else begin
            tb_d = tb_q + TB_W'(1);
        end
        gate_d      = bus.enable && (tb_d < TB_GATE);
        frame_end_s = bus.enable && (tb_q == TB_LAST);
        chan_clr_s  = frame_end_s || !bus.enable;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        measure_fre_multi_chan #(
            .CNT_WIDTH   (CNT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .sig_in  (bus.sig_in[k]),
            .gate    (gate_q),
            .clr     (chan_clr_s),
            .sig_cnt (chan_sig_s[k]),
            .ref_cnt (chan_ref_s[k]),
            .ovf     (chan_ovf_s[k]),
            .done    (chan_done_s[k])
        );
    end

    // Result latch: only channels that closed their gate report counts.
    always_comb begin
        sig_cnt_d   = sig_cnt_q;
        ref_cnt_d   = ref_cnt_q;
        ch_ovf_d    = ch_ovf_q;
        ch_nosig_d  = ch_nosig_q;
        cnt_valid_d = frame_end_s;
        if (frame_end_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (chan_done_s[k]) begin
                    sig_cnt_d[k*CNT_WIDTH +: CNT_WIDTH] = chan_sig_s[k];
                    ref_cnt_d[k*CNT_WIDTH +: CNT_WIDTH] = chan_ref_s[k];
                    ch_nosig_d[k]                       = 1'b0;
                end else begin
                    sig_cnt_d[k*CNT_WIDTH +: CNT_WIDTH] = '0;
                    ref_cnt_d[k*CNT_WIDTH +: CNT_WIDTH] = '0;
                    ch_nosig_d[k]                       = 1'b1;
                end
                ch_ovf_d[k] = chan_ovf_s[k];
            end
        end else begin
            cnt_valid_d = 1'b0;
        end
    end

    // Timebase and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_q        <= '0;
            gate_q      <= 1'b0;
            sig_cnt_q   <= '0;
            ref_cnt_q   <= '0;
            cnt_valid_q <= 1'b0;
            ch_ovf_q    <= '0;
            ch_nosig_q  <= '0;
        end else begin
            tb_q        <= tb_d;
            gate_q      <= gate_d;
            sig_cnt_q   <= sig_cnt_d;
            ref_cnt_q   <= ref_cnt_d;
            cnt_valid_q <= cnt_valid_d;
            ch_ovf_q    <= ch_ovf_d;
            ch_nosig_q  <= ch_nosig_d;
        end
    end

    assign bus.sig_cnt   = sig_cnt_q;
    assign bus.ref_cnt   = ref_cnt_q;
    assign bus.cnt_valid = cnt_valid_q;
    assign bus.ch_ovf    = ch_ovf_q;
    assign bus.ch_nosig  = ch_nosig_q;
    assign bus.gate_out  = gate_q;

endmodule

// File: tb/tb_measure_fre_multi.sv
// Scoreboard bench for measure_fre_multi: per-frame expectations are queued by
// the stimulus and checked by monitors on every cnt_valid pulse.
module tb_measure_fre_multi;

    localparam int NCH  = 4;
    localparam int W    = 32;
    localparam int GATE = 100;
    localparam int PER  = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    measure_fre_multi_if #(.NUM_CH(NCH), .CNT_WIDTH(W)) bus ();
    measure_fre_multi_if #(.NUM_CH(NCH), .CNT_WIDTH(6)) bus6 ();

    measure_fre_multi #(
        .NUM_CH(NCH), .CNT_WIDTH(W), .GATE_CYCLES(GATE),
        .PERIOD_CYCLES(PER), .SYNC_STAGES(2)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    measure_fre_multi #(
        .NUM_CH(NCH), .CNT_WIDTH(6), .GATE_CYCLES(50),
        .PERIOD_CYCLES(PER), .SYNC_STAGES(2)
    ) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    int total = 0;
    int bad   = 0;

    // Per channel: 16'hFFFF = don't care, 0 = no signal, P = period in clk cycles.
    typedef logic [NCH-1:0][15:0] exp_t;
    exp_t q[$];

    typedef struct packed {
        logic       dc;
        logic [7:0] ratio;
        logic [5:0] sig;
        logic [5:0] refc;
        logic       ovf;
    } exp6_t;
    exp6_t q6[$];

    int per  [5];
    int last [5];
    int ph   [5];

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Square-wave sources, one rising edge per period; index 4 feeds dut6 ch0.
    always @(negedge clk) begin : gen
        logic [NCH-1:0] v;
        bit sv;
        v = '0;
        for (int k = 0; k < 5; k++) begin
            if (per[k] != last[k]) begin
                last[k] = per[k];
                ph[k]   = 0;
            end
            sv = (per[k] != 0) && (ph[k] < per[k] / 2);
            if (per[k] != 0) ph[k] = (ph[k] + 1) % per[k];
            if (k < NCH) v[k] = sv;
            else bus6.sig_in = {3'b000, sv};
        end
        bus.sig_in = v;
    end

    always @(negedge clk) begin : mon
        exp_t   e;
        int     p;
        longint sv, rv;
        if (!rst && bus.cnt_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1'b0, 1, 0);
            end else begin
                e = q.pop_front();
                for (int k = 0; k < NCH; k++) begin
                    p  = int'(e[k]);
                    sv = longint'(bus.sig_cnt[k*W +: W]);
                    rv = longint'(bus.ref_cnt[k*W +: W]);
                    if (p == 0) begin
                        chk($sformatf("ch%0d_sig_zero", k), sv == 0, sv, 0);
                        chk($sformatf("ch%0d_ref_zero", k), rv == 0, rv, 0);
                        chk($sformatf("ch%0d_nosig", k), bus.ch_nosig[k] == 1'b1, bus.ch_nosig[k], 1);
                        chk($sformatf("ch%0d_ovf", k), bus.ch_ovf[k] == 1'b0, bus.ch_ovf[k], 0);
                    end else if (p != 65535) begin
                        chk($sformatf("ch%0d_ratio_p%0d", k, p), rv == longint'(p) * sv, rv, longint'(p) * sv);
                        chk($sformatf("ch%0d_sig_lo", k), sv >= GATE / p, sv, GATE / p);
                        chk($sformatf("ch%0d_sig_hi", k), sv <= (GATE + p - 1) / p + 1, sv, (GATE + p - 1) / p + 1);
                        chk($sformatf("ch%0d_nosig", k), bus.ch_nosig[k] == 1'b0, bus.ch_nosig[k], 0);
                        chk($sformatf("ch%0d_ovf", k), bus.ch_ovf[k] == 1'b0, bus.ch_ovf[k], 0);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : mon6
        exp6_t  e;
        longint sv, rv;
        if (!rst && bus6.cnt_valid && q6.size() != 0) begin
            e  = q6.pop_front();
            sv = longint'(bus6.sig_cnt[5:0]);
            rv = longint'(bus6.ref_cnt[5:0]);
            if (!e.dc) begin
                if (e.ratio == 8'd0) begin
                    chk("w6_sig", sv == longint'(e.sig), sv, longint'(e.sig));
                    chk("w6_ref_sat", rv == longint'(e.refc), rv, longint'(e.refc));
                end else begin
                    chk("w6_ratio", rv == longint'(e.ratio) * sv, rv, longint'(e.ratio) * sv);
                    chk("w6_sig_nonzero", sv > 0, sv, 1);
                end
                chk("w6_ovf", bus6.ch_ovf[0] == e.ovf, bus6.ch_ovf[0], e.ovf);
                chk("w6_nosig", bus6.ch_nosig[0] == 1'b0, bus6.ch_nosig[0], 0);
            end
        end
    end

    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.cnt_valid && cycles < 1000);
        chk("valid_seen", bus.cnt_valid == 1'b1, cycles, PER);
    endtask

    task automatic apply(input int p0, input int p1, input int p2, input int p3, input bit chk_it);
        exp_t e;
        per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
        e = '1;
        if (chk_it) begin
            e[0] = 16'(p0); e[1] = 16'(p1); e[2] = 16'(p2); e[3] = 16'(p3);
        end
        q.push_back(e);
    endtask

    task automatic run_frame(input int p0, input int p1, input int p2, input int p3, input bit chk_it);
        int c;
        wait_valid(c);
        apply(p0, p1, p2, p3, chk_it);
    endtask

    initial begin : stim
        int   c;
        int   nvalid;
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            per[k] = 0; last[k] = 0; ph[k] = 0;
        end
        rst = 1'b1;
        bus.enable  = 1'b1;
        bus6.enable = 1'b1;
        q.push_back('0);
        q6.push_back('{dc: 1'b1, ratio: 8'd0, sig: 6'd0, refc: 6'd0, ovf: 1'b0});
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Frame 0: all channels silent; first result one frame after reset.
        wait_valid(c);
        chk("first_valid_latency", c == PER, c, PER);

        // ch0 period 4, others silent; dut6 ch0 period 80 saturates 6-bit ref.
        apply(4, 0, 0, 0, 1'b1);
        per[4] = 80;
        q6.push_back('{dc: 1'b0, ratio: 8'd0, sig: 6'd1, refc: 6'd63, ovf: 1'b1});
        repeat (20) @(negedge clk);
        chk("gate_open", bus.gate_out == 1'b1, bus.gate_out, 1);
        repeat (110) @(negedge clk);
        chk("gate_closed", bus.gate_out == 1'b0, bus.gate_out, 0);

        run_frame(4, 0, 0, 0, 1'b1);
        per[4] = 4;
        q6.push_back('{dc: 1'b0, ratio: 8'd4, sig: 6'd0, refc: 6'd0, ovf: 1'b0});

        // Four distinct periods at once.
        run_frame(7, 10, 13, 3, 1'b0);
        run_frame(7, 10, 13, 3, 1'b1);

        // ch2 stops mid-gate: that frame reports no signal, then recovers.
        wait_valid(c);
        e = '1;
        e[0] = 16'd7; e[1] = 16'd10; e[2] = 16'd0; e[3] = 16'd3;
        q.push_back(e);
        repeat (50) @(negedge clk);
        per[2] = 0;
        run_frame(7, 10, 13, 3, 1'b0);
        run_frame(7, 10, 13, 3, 1'b1);

        // Reset mid-frame clears outputs at once and restarts the frame.
        wait_valid(c);
        repeat (149) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_sig_cnt", bus.sig_cnt == '0, bus.sig_cnt[31:0], 0);
        chk("rst_ref_cnt", bus.ref_cnt == '0, bus.ref_cnt[31:0], 0);
        chk("rst_valid", bus.cnt_valid == 1'b0, bus.cnt_valid, 0);
        chk("rst_ovf", bus.ch_ovf == '0, bus.ch_ovf, 0);
        chk("rst_nosig", bus.ch_nosig == '0, bus.ch_nosig, 0);
        chk("rst_gate", bus.gate_out == 1'b0, bus.gate_out, 0);
        repeat (3) @(negedge clk);
        apply(7, 10, 13, 3, 1'b0);
        rst = 1'b0;
        wait_valid(c);
        chk("post_rst_latency", c == PER, c, PER);

        // Known frame, then disable: no pulses and outputs hold.
        apply(4, 0, 0, 0, 1'b0);
        run_frame(4, 0, 0, 0, 1'b1);
        wait_valid(c);
        bus.enable = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.cnt_valid) nvalid++;
        end
        chk("disabled_no_valid", nvalid == 0, nvalid, 0);
        chk("disabled_gate", bus.gate_out == 1'b0, bus.gate_out, 0);
        chk("hold_nosig", bus.ch_nosig == 4'b1110, bus.ch_nosig, 4'b1110);
        chk("hold_ch123_ref", bus.ref_cnt[4*W-1:W] == '0, bus.ref_cnt[2*W-1:W], 0);
        chk("hold_ch0_ratio", bus.ref_cnt[W-1:0] == 32'd4 * bus.sig_cnt[W-1:0],
            bus.ref_cnt[W-1:0], 4 * bus.sig_cnt[W-1:0]);
        chk("hold_ch0_sig", bus.sig_cnt[W-1:0] >= 32'd25, bus.sig_cnt[W-1:0], 25);

        // Re-enable: first result one full frame later.
        bus.enable = 1'b1;
        apply(4, 0, 0, 0, 1'b1);
        wait_valid(c);
        chk("post_enable_latency", c == PER, c, PER);

        @(negedge clk);
        chk("queue_drained", q.size() == 0, q.size(), 0);
        chk("queue6_drained", q6.size() == 0, q6.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
